// File: rtl/coproc_pkg.sv
// coproc_pkg: shared UART constants and FSM state encodings for the coprocessor.
package coproc_pkg;
    localparam int   DEFAULT_CLKS_PER_BIT = 868;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   FRAME_BITS           = 10;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND} top_state_t;
    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; LSB first, CLKS_PER_BIT cycles per bit.
// Ports: clk, rst (sync, active-low), start/data (latched when idle or on
// byte_done), tx (registered line), busy, byte_done (last stop-bit cycle).
module uart_tx_byte
    import coproc_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    byte_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] sh, sh_n;
    logic tx_n, bit_end;
    assign bit_end = cnt == LAST;
    assign busy = state != B_IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= B_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            tx      <= STOP_BIT;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            sh      <= sh_n;
            tx      <= tx_n;
        end
    end
    always_comb begin
        state_n   = state;
        cnt_n     = bit_end ? '0 : cnt + CW'(1);
        bit_n     = bit_cnt;
        sh_n      = sh;
        tx_n      = tx;
        byte_done = 1'b0;
        case (state)
            B_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = B_START;
                    sh_n    = data;
                    tx_n    = START_BIT;
                end
            end
            B_START: if (bit_end) begin
                state_n = B_DATA;
                bit_n   = '0;
                tx_n    = sh[0];
            end
            B_DATA: if (bit_end) begin
                sh_n = sh >> 1;
                if (bit_cnt == 3'd7) begin
                    state_n = B_STOP;
                    tx_n    = STOP_BIT;
                end else begin
                    bit_n = bit_cnt + 3'd1;
                    tx_n  = sh[1];
                end
            end
            default: if (bit_end) begin
                // the next frame's start bit begins right after this stop bit
                byte_done = 1'b1;
                if (start) begin
                    state_n = B_START;
                    sh_n    = data;
                    tx_n    = START_BIT;
                end else begin
                    state_n = B_IDLE;
                end
            end
        endcase
    end
endmodule

// File: rtl/coprocessor_uart_tx.sv
// coprocessor_uart_tx: buffers coprocessor result words and sends them MSB byte first as 8N1.
// Ports: clk, rst (sync, active-low), dout/dout_valid (result strobe, no backpressure),
// tx (serial line), ready (pending slot empty), tx_busy, word_done (1-cycle pulse),
// overflow (sticky drop flag).
module coprocessor_uart_tx
    import coproc_pkg::*;
#(
    parameter int WIDTH_DOUT   = 128,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_DOUT-1:0] dout,
    input  logic                  dout_valid,
    output logic                  tx,
    output logic                  ready,
    output logic                  tx_busy,
    output logic                  word_done,
    output logic                  overflow
);
    localparam int NBYTES = WIDTH_DOUT / 8;
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    top_state_t state, state_n;
    logic [WIDTH_DOUT-1:0] pending, active;
    logic pending_valid, accept, start, byte_done, eng_busy, last_done;
    logic [IW-1:0] byte_idx;
    logic [7:0] data;
    assign ready     = !pending_valid;
    assign accept    = dout_valid && ready;
    assign tx_busy   = state != T_IDLE || eng_busy;
    assign last_done = state == T_SEND && byte_done && byte_idx == LAST_IDX;
    // active is pre-shifted so its top byte is always the next byte to send
    assign data = state == T_LOAD ? pending[WIDTH_DOUT-1 -: 8] : active[WIDTH_DOUT-1 -: 8];
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data     (data),
        .tx       (tx),
        .busy     (eng_busy),
        .byte_done(byte_done)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= T_IDLE;
            pending_valid <= 1'b0;
            byte_idx      <= '0;
            word_done     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            pending_valid <= accept || (pending_valid && state != T_LOAD);
            byte_idx      <= state == T_LOAD ? '0 : (state == T_SEND && byte_done && !last_done) ? byte_idx + IW'(1) : byte_idx;
            word_done     <= last_done;
            overflow      <= overflow || (dout_valid && !ready);
        end
    end
    always_ff @(posedge clk) begin
        if (accept) pending <= dout;
        if (state == T_LOAD) active <= pending << 8;
        else if (state == T_SEND && start) active <= active << 8;
    end
    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            T_IDLE: state_n = pending_valid ? T_LOAD : T_IDLE;
            T_LOAD: begin
                start   = 1'b1;
                state_n = T_SEND;
            end
            default: if (byte_done) begin
                start   = !last_done;
                state_n = last_done ? T_IDLE : T_SEND;
            end
        endcase
    end
endmodule

// File: tb/tb_coprocessor_uart_tx.sv
// tb_coprocessor_uart_tx: directed bench with a bit-centre UART decoder on tx.
module tb_coprocessor_uart_tx;
    localparam int C = 4;
    localparam int W = 128;
    logic clk = 1'b0, rst = 1'b0, dout_valid = 1'b0;
    logic [W-1:0] dout = '0;
    logic tx, ready, tx_busy, word_done, overflow;
    int cyc = 0, acc = 0, pass_cnt = 0, total = 0;
    int start_q[$], wd_q[$];
    logic [7:0] bytes_q[$];
    logic [9:0] frames_q[$];
    logic mon_on = 1'b0;
    int mon_cnt = 0;
    logic [9:0] frame = '0;

    coprocessor_uart_tx #(.WIDTH_DOUT(W), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .dout(dout), .dout_valid(dout_valid),
        .tx(tx), .ready(ready), .tx_busy(tx_busy), .word_done(word_done), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (word_done) wd_q.push_back(cyc);
            if (!rst) mon_on = 1'b0;
            else if (!mon_on) begin
                if (tx === 1'b0) begin
                    mon_on = 1'b1;
                    mon_cnt = 0;
                    frame = '0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % C == C / 2) begin
                    frame[mon_cnt / C] = tx;
                    if (mon_cnt / C == 9) begin
                        mon_on = 1'b0;
                        frames_q.push_back(frame);
                        bytes_q.push_back(frame[8:1]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        start_q.delete();
        wd_q.delete();
        bytes_q.delete();
        frames_q.delete();
    endtask

    task automatic send(input logic [W-1:0] w);
        dout = w;
        dout_valid = 1'b1;
        acc = cyc + 1;
        step();
        dout_valid = 1'b0;
    endtask

    task automatic wait_wd(input int n, input int budget);
        int k = 0;
        while (wd_q.size() < n && k < budget) begin
            step();
            k++;
        end
        total++;
        if (wd_q.size() < n) $display("FAIL wait_word_done: got %0d pulses want %0d", wd_q.size(), n);
        else pass_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        clear_q();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else pass_cnt++;
        total++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else pass_cnt++;
        total++; if (word_done !== 1'b0) $display("FAIL reset_word_done: got %b want 0", word_done); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else pass_cnt++;
        rst = 1'b1;
        step();
        clear_q();
    endtask

    task automatic test_single();
        int bad = 0;
        clear_q();
        send(128'h65);
        total++; if (ready !== 1'b0) $display("FAIL single_ready_after_accept: got %b want 0", ready); else pass_cnt++;
        wait_wd(1, 1000);
        for (int i = 0; i < 15; i++) if (bytes_q[i] !== 8'h00) bad++;
        total++; if (bytes_q.size() !== 16) $display("FAIL single_nbytes: got %0d want 16", bytes_q.size()); else pass_cnt++;
        total++; if (bad !== 0) $display("FAIL single_zero_bytes: got %0d bad want 0", bad); else pass_cnt++;
        total++; if (bytes_q[15] !== 8'h65) $display("FAIL single_last_byte: got %h want 65", bytes_q[15]); else pass_cnt++;
        total++; if (start_q[0] - acc !== 2) $display("FAIL single_start_latency: got %0d want 2", start_q[0] - acc); else pass_cnt++;
        total++; if (wd_q[0] - start_q[0] !== 640) $display("FAIL single_word_len: got %0d want 640", wd_q[0] - start_q[0]); else pass_cnt++;
        step();
        total++; if ({tx, tx_busy, ready, word_done} !== 4'b1010) $display("FAIL single_idle_after: got %b want 1010", {tx, tx_busy, ready, word_done}); else pass_cnt++;
    endtask

    task automatic test_order();
        int bad = 0;
        clear_q();
        send(128'h0102030405060708090a0b0c0d0e0f10);
        wait_wd(1, 1000);
        for (int i = 0; i < 16; i++) if (bytes_q[i] !== 8'(i + 1)) bad++;
        total++; if (bad !== 0 || bytes_q.size() !== 16) $display("FAIL order_bytes: got %0d bad of %0d want 0 of 16", bad, bytes_q.size()); else pass_cnt++;
        total++; if (frames_q[0] !== 10'h202) $display("FAIL order_frame01: got %b want 1000000010", frames_q[0]); else pass_cnt++;
        total++; if (frames_q[15] !== 10'h220) $display("FAIL order_frame10: got %b want 1000100000", frames_q[15]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        clear_q();
        send(128'd101);
        total++; if (ready !== 1'b0) $display("FAIL b2b_ready_pending: got %b want 0", ready); else pass_cnt++;
        step();
        total++; if ({tx_busy, ready} !== 2'b10) $display("FAIL b2b_load_status: got %b want 10", {tx_busy, ready}); else pass_cnt++;
        step();
        total++; if (ready !== 1'b1) $display("FAIL b2b_ready_after_load: got %b want 1", ready); else pass_cnt++;
        send(128'd49);
        wait_wd(2, 2000);
        total++; if (bytes_q.size() !== 32) $display("FAIL b2b_nbytes: got %0d want 32", bytes_q.size()); else pass_cnt++;
        total++; if (bytes_q[15] !== 8'd101 || bytes_q[31] !== 8'd49) $display("FAIL b2b_values: got %h,%h want 65,31", bytes_q[15], bytes_q[31]); else pass_cnt++;
        total++; if (start_q[16] - wd_q[0] !== 2) $display("FAIL b2b_gap: got %0d want 2", start_q[16] - wd_q[0]); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", overflow); else pass_cnt++;
    endtask

    task automatic test_overflow();
        send(128'd3);
        step();
        step();
        send(128'd4);
        total++; if (overflow !== 1'b0) $display("FAIL ovf_before: got %b want 0", overflow); else pass_cnt++;
        send(128'd5);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_rise: got %b want 1", overflow); else pass_cnt++;
        wait_wd(2, 2000);
        repeat (700) step();
        total++; if (wd_q.size() !== 2 || bytes_q.size() !== 32) $display("FAIL ovf_count: got %0d words %0d bytes want 2 32", wd_q.size(), bytes_q.size()); else pass_cnt++;
        total++; if (bytes_q[15] !== 8'd3 || bytes_q[31] !== 8'd4) $display("FAIL ovf_values: got %h,%h want 03,04", bytes_q[15], bytes_q[31]); else pass_cnt++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int k = 0, bad = 0;
        logic [W-1:0] w = 128'h00112233445566778899aabbccddeeff;
        clear_q();
        send(128'hfedcba98765432100123456789abcdef);
        while (bytes_q.size() < 5 && k < 1000) begin
            step();
            k++;
        end
        repeat (10) step();
        rst = 1'b0;
        step();
        total++; if ({tx, ready, tx_busy, overflow} !== 4'b1100) $display("FAIL mid_reset_state: got %b want 1100", {tx, ready, tx_busy, overflow}); else pass_cnt++;
        step();
        rst = 1'b1;
        step();
        clear_q();
        send(w);
        wait_wd(1, 1000);
        for (int i = 0; i < 16; i++) if (bytes_q[i] !== w[W-1-8*i -: 8]) bad++;
        total++; if (bad !== 0 || bytes_q.size() !== 16) $display("FAIL mid_after_word: got %0d bad of %0d want 0 of 16", bad, bytes_q.size()); else pass_cnt++;
    endtask

    task automatic test_accept_during_load();
        clear_q();
        send(128'd7);
        step();
        total++; if ({tx_busy, ready} !== 2'b10) $display("FAIL load_status: got %b want 10", {tx_busy, ready}); else pass_cnt++;
        send(128'd8);
        total++; if (overflow !== 1'b1) $display("FAIL load_overflow: got %b want 1", overflow); else pass_cnt++;
        wait_wd(1, 1000);
        repeat (700) step();
        total++; if (wd_q.size() !== 1 || bytes_q.size() !== 16 || bytes_q[15] !== 8'd7) $display("FAIL load_dropped: got %0d words %0d bytes want 1 16", wd_q.size(), bytes_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_back_to_back();
        do_reset();
        test_overflow();
        test_reset_mid_frame();
        do_reset();
        test_accept_during_load();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
